// File: rtl/gf2m_mult_serial_pkg.sv
// gf2_pkg: shared definitions for the digit-serial GF(2)[x] / GF(2^W) multiplier.
//   state_e   : FSM states of gf2m_mult_serial
//   MODE_*    : encoding of the mode input (raw product vs. reduced product)
//   n_digits  : number of RUN cycles (one per D-bit digit of b)
//   n_red     : number of REDUCE cycles (D high-order positions cleared per cycle)
package gf2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic MODE_RAW = 1'b0;
  localparam logic MODE_RED = 1'b1;

  function automatic int n_digits(input int w, input int d);
    return w / d;
  endfunction

  // Positions 2W-2 .. W must be cleared: W-1 of them, D per cycle, rounded up.
  function automatic int n_red(input int w, input int d);
    return (w - 1 + d - 1) / d;
  endfunction

endpackage

// File: rtl/gf2m_mult_serial_clmul_digit.sv
// clmul_digit: combinational W x D carry-less partial product.
//   a_i : W-bit multiplicand
//   b_i : D-bit digit of the multiplier
//   p_o : W+D-1 bit product a_i * b_i over GF(2)[x] (AND/XOR only, no carries)
module clmul_digit
  import gf2_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic [W-1:0]   a_i,
  input  logic [D-1:0]   b_i,
  output logic [W+D-2:0] p_o
);

  localparam int PW = W + D - 1;

  // XOR together the shifted copies of a_i selected by each digit bit.
  always_comb begin
    p_o = '0;
    for (int j = 0; j < D; j++) begin
      if (b_i[j]) begin
        p_o = p_o ^ (PW'(a_i) << j);
      end else begin
        p_o = p_o;
      end
    end
  end

endmodule

// File: rtl/gf2m_mult_serial.sv
// gf2m_mult_serial: digit-serial carry-less multiplier with optional reduction
// modulo POLY (GF(2^W) multiply), behind valid/ready handshakes.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready only in IDLE, not in reset)
//   a, b, mode          : operands; mode 0 = raw product, 1 = reduced mod POLY
//   out_valid/out_ready : result handshake; y held stable under backpressure
//   y                   : 2W-1 bit result (reduced mode: upper W-1 bits are 0)
//   busy                : high whenever an operation is in flight
module gf2m_mult_serial
  import gf2_pkg::*;
#(
  parameter int         W    = 8,
  parameter int         D    = 2,
  parameter logic [W:0] POLY = 9'h11B
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-2:0] y,
  output logic           busy
);

  localparam int AW   = 2 * W - 1;
  localparam int PW   = W + D - 1;
  localparam int ND   = n_digits(W, D);
  localparam int NR   = n_red(W, D);
  localparam int NMAX = (ND > NR) ? ND : NR;
  localparam int KW   = (NMAX > 1) ? $clog2(NMAX) : 1;

  if (W < 2) begin : g_chk_w
    $error("gf2m_mult_serial: W must be at least 2");
  end
  if ((W % D) != 0) begin : g_chk_d
    $error("gf2m_mult_serial: D must divide W");
  end
  if (POLY[W] != 1'b1) begin : g_chk_poly
    $error("gf2m_mult_serial: POLY bit W must be set");
  end

  state_e          state_q;
  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   acc_d;
  logic [AW-1:0]   red_s;
  logic [KW-1:0]   k_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            mode_q;
  logic [AW-1:0]   y_q;
  logic            out_valid_q;
  logic [D-1:0]    digit_s;
  logic [PW-1:0]   pp_s;

  // k_q doubles as digit index in RUN and as reduction step in REDUCE.
  assign digit_s = D'(b_q >> (int'(k_q) * D));

  clmul_digit #(
    .W (W),
    .D (D)
  ) u_clmul_digit (
    .a_i (a_q),
    .b_i (digit_s),
    .p_o (pp_s)
  );

  // One reduction step: D positions, highest first, chained so a bit set by
  // an earlier position in the same cycle is seen by the later ones.
  always_comb begin
    red_s = acc_q;
    for (int j = 0; j < D; j++) begin
      automatic int pos = AW - 1 - int'(k_q) * D - j;
      if ((pos >= W) && red_s[pos]) begin
        red_s = red_s ^ (AW'(POLY) << (pos - W));
      end else begin
        red_s = red_s;
      end
    end
  end

  // Next accumulator value for the current state.
  always_comb begin
    acc_d = acc_q;
    case (state_q)
      RUN:     acc_d = acc_q ^ (AW'(pp_s) << (int'(k_q) * D));
      REDUCE:  acc_d = red_s;
      default: acc_d = acc_q;
    endcase
  end

  // Control FSM, operand/accumulator state and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= MODE_RAW;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            mode_q  <= mode;
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (k_q == KW'(ND - 1)) begin
            k_q     <= '0;
            state_q <= (mode_q == MODE_RED) ? REDUCE : DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        REDUCE: begin
          acc_q <= acc_d;
          if (k_q == KW'(NR - 1)) begin
            k_q     <= '0;
            state_q <= DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          // First DONE cycle registers the result; afterwards wait for the
          // consumer. A simultaneous in_valid is not looked at here.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            y_q         <= acc_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule

// File: tb/tb_gf2m_mult_serial.sv
// Scoreboard bench for gf2m_mult_serial: default instance driven with directed
// vectors, plus W=16/D=4 and W=8/D=8 instances driven with random operands
// checked against a bench-side carry-less/reduction model.
module tb_gf2m_mult_serial;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance 0: W=8 D=2
  logic        in_valid0, in_ready0, mode0, out_valid0, out_ready0, busy0;
  logic [7:0]  a0, b0;
  logic [14:0] y0;
  // instance 1: W=16 D=4
  logic        in_valid1, in_ready1, mode1, out_valid1, out_ready1, busy1;
  logic [15:0] a1, b1;
  logic [30:0] y1;
  // instance 2: W=8 D=8
  logic        in_valid2, in_ready2, mode2, out_valid2, out_ready2, busy2;
  logic [7:0]  a2, b2;
  logic [14:0] y2;

  gf2m_mult_serial #(.W(8), .D(2), .POLY(9'h11B)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .mode(mode0), .out_valid(out_valid0),
    .out_ready(out_ready0), .y(y0), .busy(busy0));

  gf2m_mult_serial #(.W(16), .D(4), .POLY(17'h1002B)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .mode(mode1), .out_valid(out_valid1),
    .out_ready(out_ready1), .y(y1), .busy(busy1));

  gf2m_mult_serial #(.W(8), .D(8), .POLY(9'h11B)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .mode(mode2), .out_valid(out_valid2),
    .out_ready(out_ready2), .y(y2), .busy(busy2));

  typedef struct {
    int          id;
    logic [63:0] y;
    int          lat;
    int          acc_cyc;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t cur[3];
  bit   seen[3];
  int   vecs = 0;
  int   errs = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference models
  function automatic logic [63:0] clmul_ref(input logic [31:0] x, input logic [31:0] z, input int w);
    logic [63:0] r = 64'd0;
    for (int i = 0; i < w; i++) if (z[i]) r = r ^ (64'(x) << i);
    return r;
  endfunction

  function automatic logic [63:0] reduce_ref(input logic [63:0] p, input int w, input logic [32:0] poly);
    logic [63:0] r = p;
    for (int i = 2 * w - 2; i >= w; i--) if (r[i]) r = r ^ (64'(poly) << (i - w));
    return r;
  endfunction

  function automatic logic rdy(input int id);
    case (id)
      0:       return in_ready0;
      1:       return in_ready1;
      default: return in_ready2;
    endcase
  endfunction

  function automatic logic ov(input int id);
    case (id)
      0:       return out_valid0;
      1:       return out_valid1;
      default: return out_valid2;
    endcase
  endfunction

  task automatic set_in(input int id, input logic v, input logic [31:0] x, input logic [31:0] z, input logic m);
    case (id)
      0: begin in_valid0 = v; a0 = x[7:0];  b0 = z[7:0];  mode0 = m; end
      1: begin in_valid1 = v; a1 = x[15:0]; b1 = z[15:0]; mode1 = m; end
      default: begin in_valid2 = v; a2 = x[7:0]; b2 = z[7:0]; mode2 = m; end
    endcase
  endtask

  // Monitor: pop on the first valid cycle, then hold y against it while valid.
  task automatic mon(input int id, input logic v, input logic [63:0] yv);
    if (v === 1'b1) begin
      if (!seen[id]) begin
        seen[id] = 1'b1;
        if (sb.size() == 0) begin
          chk($sformatf("unexpected_output_inst%0d", id), yv, 64'hDEAD);
          cur[id] = '{id, yv, 0, cyc, "none"};
        end else begin
          cur[id] = sb.pop_front();
          chk({cur[id].nm, "_inst"}, 64'(id), 64'(cur[id].id));
          chk({cur[id].nm, "_latency"}, 64'(cyc - cur[id].acc_cyc), 64'(cur[id].lat));
        end
      end
      chk({cur[id].nm, "_y"}, yv, cur[id].y);
    end else begin
      seen[id] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, out_valid0, 64'(y0));
    mon(1, out_valid1, 64'(y1));
    mon(2, out_valid2, 64'(y2));
  end

  task automatic issue(input int id, input logic [31:0] x, input logic [31:0] z, input logic m,
                       input logic [63:0] ye, input int lat, input string nm);
    int n = 0;
    @(negedge clk);
    while (!rdy(id) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_in_ready"}, 64'(rdy(id)), 64'd1);
    set_in(id, 1'b1, x, z, m);
    sb.push_back('{id, ye, lat, cyc + 1, nm});
    @(negedge clk);
    set_in(id, 1'b0, x, z, m);
  endtask

  task automatic drain(input int id);
    int n = 0;
    while ((sb.size() != 0 || ov(id)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vecs++;
      errs++;
      $display("FAIL drain_timeout_inst%0d: got pending %0d expected 0", id, sb.size());
      sb.delete();
    end
  endtask

  typedef struct { logic [7:0] a; logic [7:0] b; logic m; logic [15:0] y; } vec_t;
  vec_t vt[8];

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rm;
    logic [63:0] e;
    int          n;

    vt[0] = '{8'h53, 8'hCA, 1'b0, 16'h3F7E};
    vt[1] = '{8'h53, 8'hCA, 1'b1, 16'h0001};
    vt[2] = '{8'h57, 8'h83, 1'b1, 16'h00C1};
    vt[3] = '{8'hFF, 8'hFF, 1'b0, 16'h5555};
    vt[4] = '{8'h80, 8'h80, 1'b0, 16'h4000};
    vt[5] = '{8'h00, 8'hFF, 1'b0, 16'h0000};
    vt[6] = '{8'h02, 8'h87, 1'b0, 16'h010E};
    vt[7] = '{8'h02, 8'h87, 1'b1, 16'h0015};

    rst = 1'b1;
    set_in(0, 1'b0, 32'd0, 32'd0, 1'b0);
    set_in(1, 1'b0, 32'd0, 32'd0, 1'b0);
    set_in(2, 1'b0, 32'd0, 32'd0, 1'b0);
    out_ready0 = 1'b1; out_ready1 = 1'b1; out_ready2 = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready0), 64'd0);
    chk("rst_out_valid", 64'(out_valid0), 64'd0);
    chk("rst_y", 64'(y0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready0), 64'd1);

    // Directed vectors on the default instance
    for (int i = 0; i < 8; i++) begin
      issue(0, 32'(vt[i].a), 32'(vt[i].b), vt[i].m, 64'(vt[i].y),
            vt[i].m ? 9 : 5, $sformatf("vec%0d", i));
      drain(0);
    end

    // Backpressure: result held for 10 cycles, in_valid pulses ignored
    out_ready0 = 1'b0;
    issue(0, 32'h57, 32'h83, 1'b0, 64'h2B79, 5, "bp");
    n = 0;
    while (out_valid0 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", 64'(out_valid0), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid0), 64'd1);
      chk("bp_in_ready", 64'(in_ready0), 64'd0);
      chk("bp_busy", 64'(busy0), 64'd1);
      set_in(0, (i % 2) == 0, 32'h11, 32'h22, 1'b1);
    end
    set_in(0, 1'b0, 32'h0, 32'h0, 1'b0);
    out_ready0 = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", 64'(out_valid0), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready0), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("bp_no_queued_op", 64'(out_valid0), 64'd0);
    end

    // in_valid held through DONE: second accept only after the output handshake
    @(negedge clk);
    set_in(0, 1'b1, 32'h02, 32'h87, 1'b0);
    n = cyc;
    sb.push_back('{0, 64'h010E, 5, n + 1, "hold_first"});
    sb.push_back('{0, 64'h010E, 5, n + 8, "hold_second"});
    while (cyc < n + 8) @(negedge clk);
    set_in(0, 1'b0, 32'h02, 32'h87, 1'b0);
    drain(0);

    // Reset during the second RUN cycle
    @(negedge clk);
    set_in(0, 1'b1, 32'h53, 32'hCA, 1'b1);
    @(negedge clk);
    set_in(0, 1'b0, 32'h53, 32'hCA, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid0), 64'd0);
    chk("midrst_y", 64'(y0), 64'd0);
    chk("midrst_busy", 64'(busy0), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready0), 64'd1);
    issue(0, 32'h57, 32'h83, 1'b1, 64'h00C1, 9, "after_rst");
    drain(0);

    // Parameter sweep: W=16 D=4 (lat 5 / 9), W=8 D=8 (lat 2 / 3)
    issue(1, 32'hFFFF, 32'hFFFF, 1'b0, 64'h55555555, 5, "w16_ones");
    drain(1);
    for (int i = 0; i < 6; i++) begin
      ra = $urandom_range(0, 65535);
      rb = $urandom_range(0, 65535);
      rm = i[0];
      e  = clmul_ref(ra, rb, 16);
      if (rm) e = reduce_ref(e, 16, 33'h1002B);
      issue(1, ra, rb, rm, e, rm ? 9 : 5, $sformatf("w16_rand%0d", i));
      drain(1);
    end
    for (int i = 0; i < 6; i++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      rm = i[0];
      e  = clmul_ref(ra, rb, 8);
      if (rm) e = reduce_ref(e, 8, 33'h11B);
      issue(2, ra, rb, rm, e, rm ? 3 : 2, $sformatf("d8_rand%0d", i));
      drain(2);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
